// File: rtl/kernel_window_buffer.sv
// kernel_window_buffer
//
// Collects the per-column pixel stream from the masked-2D-filter address
// generator into n-tall columns. It keeps a sliding n x n window of the most
// recent n columns. Once n columns are held, it presents the whole window to
// the weighted order-statistic sorter each time another column completes.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   rst            asynchronous active-high reset
//   n              kernel size (quasi-static, changes only during reset)
//   in_valid       a read slot is presented this cycle
//   in_pad         slot is out of image bounds, PAD_VAL replaces in_data
//   in_data        pixel read data aligned with in_valid
//   kernel_newline row-boundary flush strobe
//   win_valid      one-cycle pulse, win_data holds a complete window
//   win_data       flat window bus, element (c,r) at bit (c*MAX_N+r)*PIX
//   col_count      complete columns held, saturating at the effective size
module kernel_window_buffer #(
  parameter int WORD = 16,
  parameter int MAX_N = 25,
  parameter int PIX = 8,
  parameter logic [PIX-1:0] PAD_VAL = '0,
  localparam int C_BITS = $clog2(MAX_N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD-1:0]            n,
  input  logic                       in_valid,
  input  logic                       in_pad,
  input  logic [PIX-1:0]             in_data,
  input  logic                       kernel_newline,
  output logic                       win_valid,
  output logic [MAX_N*MAX_N*PIX-1:0] win_data,
  output logic [C_BITS-1:0]          col_count
);

  logic [C_BITS-1:0] n_eff;
  logic [C_BITS-1:0] n_last;
  logic [C_BITS-1:0] row_idx;
  logic [C_BITS-1:0] count_next;
  logic              accept;
  logic              col_done;
  logic [PIX-1:0]    slot_val;

  logic [PIX-1:0] col_buf   [MAX_N];
  logic [PIX-1:0] new_col   [MAX_N];
  logic [PIX-1:0] win_mem   [MAX_N][MAX_N];
  logic [PIX-1:0] win_shift [MAX_N][MAX_N];

  // Clamp the requested kernel size into 1..MAX_N. Odd and even sizes are
  // both accepted unchanged.
  always_comb begin
    n_eff = n[C_BITS-1:0];
    if (n == '0) begin
      n_eff = C_BITS'(1);
    end else if (n > WORD'(MAX_N)) begin
      n_eff = C_BITS'(MAX_N);
    end
  end

  // Slot acceptance and column completion. A flush on the same edge wins
  // over any presented slot, so the slot is dropped.
  always_comb begin
    n_last     = n_eff - C_BITS'(1);
    accept     = in_valid && !kernel_newline;
    col_done   = accept && (row_idx == n_last);
    slot_val   = in_pad ? PAD_VAL : in_data;
    count_next = (col_count >= n_eff) ? n_eff : col_count + C_BITS'(1);
  end

  // The completed column includes the pixel arriving on the completing edge,
  // so that pixel is merged in here instead of waiting for col_buf. Rows at
  // or beyond n_eff are forced to zero so inactive window positions stay 0.
  always_comb begin
    for (int r = 0; r < MAX_N; r++) begin
      new_col[r] = '0;
      if (C_BITS'(r) == row_idx) begin
        new_col[r] = slot_val;
      end else if (C_BITS'(r) < n_eff) begin
        new_col[r] = col_buf[r];
      end
    end
  end

  // Shift source for the sliding window: column c takes column c+1. The
  // last physical column has no successor, and only the load path ever
  // writes it.
  always_comb begin
    for (int c = 0; c < MAX_N; c++) begin
      for (int r = 0; r < MAX_N; r++) begin
        win_shift[c][r] = '0;
      end
    end
    for (int c = 0; c < MAX_N - 1; c++) begin
      for (int r = 0; r < MAX_N; r++) begin
        win_shift[c][r] = win_mem[c+1][r];
      end
    end
  end

  // Column assembly. row_idx points at the next row to fill. A flush or a
  // completed column returns it to the top. Stale rows from an abandoned
  // column are harmless because every row below n_eff is rewritten before
  // the next column completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx <= '0;
      for (int r = 0; r < MAX_N; r++) begin
        col_buf[r] <= '0;
      end
    end else if (kernel_newline) begin
      row_idx <= '0;
    end else if (accept) begin
      row_idx <= col_done ? '0 : row_idx + C_BITS'(1);
      for (int r = 0; r < MAX_N; r++) begin
        if (C_BITS'(r) == row_idx) begin
          col_buf[r] <= slot_val;
        end
      end
    end
  end

  // Window storage, column counter and the window-ready pulse. The storage
  // is the output register itself, so win_data stays stable between column
  // completions. A flush only restarts the count and leaves the stored
  // window alone. The pulse fires once enough fresh columns have arrived
  // again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      col_count <= '0;
      for (int c = 0; c < MAX_N; c++) begin
        for (int r = 0; r < MAX_N; r++) begin
          win_mem[c][r] <= '0;
        end
      end
    end else begin
      win_valid <= 1'b0;
      if (kernel_newline) begin
        col_count <= '0;
      end else if (col_done) begin
        col_count <= count_next;
        win_valid <= (count_next == n_eff);
        for (int c = 0; c < MAX_N; c++) begin
          for (int r = 0; r < MAX_N; r++) begin
            if (C_BITS'(c) == n_last) begin
              win_mem[c][r] <= new_col[r];
            end else if (C_BITS'(c) < n_last) begin
              win_mem[c][r] <= win_shift[c][r];
            end
          end
        end
      end
    end
  end

  // Flatten the window onto the output bus, oldest column at the low end.
  always_comb begin
    win_data = '0;
    for (int c = 0; c < MAX_N; c++) begin
      for (int r = 0; r < MAX_N; r++) begin
        win_data[(c*MAX_N+r)*PIX +: PIX] = win_mem[c][r];
      end
    end
  end

endmodule
